// File: rtl/uab_rv_pkg.sv
// rtl/uab_rv_pkg.sv - shared register map and debounce constants for the key PIO
package uab_rv_pkg;

   typedef enum logic [1:0] {
      REG_DATA = 2'd0,
      REG_MASK = 2'd1,
      REG_EDGE = 2'd2,
      REG_RSVD = 2'd3
   } reg_addr_e;

   // 20 ms at 50 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/uab_debounce.sv
// rtl/uab_debounce.sv - per-key synchronizer and stable-time debouncer (stable: 1 = pressed)
module uab_debounce
   import uab_rv_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key,
   output logic stable,
   output logic rise
);

   localparam int unsigned   CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          done;

   // Keys are active-low, so the released level is the synchronizer reset value
   assign differ = (~sync2) != stable;
   assign done   = differ && (cnt == LAST);
   assign rise   = done && !stable;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         if (!differ || done) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (done) begin
            stable <= ~stable;
         end
      end
   end

endmodule

// File: rtl/uab_key_pio.sv
// rtl/uab_key_pio.sv - debounced key PIO with DATA/MASK/EDGE registers and level irq
module uab_key_pio
   import uab_rv_pkg::*;
#(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] key_in,
   input  logic             chipselect,
   input  logic [1:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] edge_clr;
   logic             wr_en;
   logic             rd_en;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_key
      uab_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset_n(reset_n),
         .key    (key_in[i]),
         .stable (stable[i]),
         .rise   (rise[i])
      );
   end

   assign wr_en        = chipselect && write;
   assign rd_en        = chipselect && read;
   assign edge_clr     = (wr_en && address == REG_EDGE) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^writedata;

   always_comb begin
      rd_mux = '0;
      case (address)
         REG_DATA: rd_mux = 32'(stable);
         REG_MASK: rd_mux = 32'(mask_q);
         REG_EDGE: rd_mux = 32'(edge_q);
         default:  rd_mux = '0;
      endcase
   end

   // Read mux samples pre-write state; a new edge beats a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q   <= '0;
         edge_q   <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         if (wr_en && address == REG_MASK) begin
            mask_q <= writedata[WIDTH-1:0];
         end
         edge_q <= (edge_q & ~edge_clr) | rise;
         irq    <= |(edge_q & mask_q);
         if (rd_en) begin
            readdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_uab_key_pio.sv
// tb/tb_uab_key_pio.sv - directed self-checking bench for uab_key_pio with DEBOUNCE_CYCLES=4
module tb_uab_key_pio;

   localparam int WIDTH = 2;
   localparam int DB    = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] key_in;
   logic             chipselect;
   logic [1:0]       address;
   logic             read;
   logic             write;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic             irq;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uab_key_pio #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_in    (key_in),
      .chipselect(chipselect),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge with readdata settled
   task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      read       = rd;
      write      = wr;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
      bus(1'b1, 1'b0, a, 32'h0);
      check(tag, readdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus(1'b0, 1'b1, a, d);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n    = 1'b0;
      key_in     = '1;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      address    = 2'd0;
      writedata  = 32'h0;
      idle(3);
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      idle(2);
      rd_chk(2'd0, 32'h0, "rst_data");
      rd_chk(2'd1, 32'h0, "rst_mask");
      rd_chk(2'd2, 32'h0, "rst_edge");

      // 3-cycle glitch must not qualify
      key_in[0] = 1'b0;
      idle(3);
      key_in[0] = 1'b1;
      idle(8);
      rd_chk(2'd0, 32'h0, "glitch_data");
      rd_chk(2'd2, 32'h0, "glitch_edge");

      // Held press: stable rises on the 6th edge after the change
      key_in[0]  = 1'b0;
      idle(5);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = 2'd0;
      @(negedge clk);
      check("press_data_t6_pre", readdata, 32'h0);
      @(negedge clk);
      check("press_data_t6_post", readdata, 32'h1);
      chipselect = 1'b0;
      read       = 1'b0;
      idle(3);
      rd_chk(2'd2, 32'h1, "press_edge");
      check("press_irq_masked", {31'b0, irq}, 32'h0);
      key_in[0] = 1'b1;
      idle(8);
      rd_chk(2'd0, 32'h0, "release_data");
      rd_chk(2'd2, 32'h1, "release_no_edge");
      wr(2'd2, 32'h1);
      rd_chk(2'd2, 32'h0, "edge_w1c");

      // Masked interrupt set and clear
      wr(2'd1, 32'h1);
      rd_chk(2'd1, 32'h1, "mask_rw");
      key_in[0] = 1'b0;
      idle(10);
      check("irq_set", {31'b0, irq}, 32'h1);
      wr(2'd2, 32'h1);
      check("irq_hold", {31'b0, irq}, 32'h1);
      idle(1);
      check("irq_clear", {31'b0, irq}, 32'h0);
      rd_chk(2'd2, 32'h0, "irq_edge_clr");
      key_in[0] = 1'b1;
      idle(8);

      // Set on key 1 coincides with its clear
      key_in[1] = 1'b0;
      idle(5);
      wr(2'd2, 32'h2);
      rd_chk(2'd2, 32'h2, "set_beats_clr");
      check("irq_key1_unmasked", {31'b0, irq}, 32'h0);
      wr(2'd2, 32'h2);
      rd_chk(2'd2, 32'h0, "key1_clr");
      key_in[1] = 1'b1;
      idle(8);

      // Reset mid-count at count 2
      rd_chk(2'd1, 32'h1, "pre_reset_mask");
      key_in[0] = 1'b0;
      idle(4);
      reset_n   = 1'b0;
      key_in[0] = 1'b1;
      idle(1);
      check("midrst_readdata", readdata, 32'h0);
      check("midrst_irq", {31'b0, irq}, 32'h0);
      idle(1);
      reset_n = 1'b1;
      idle(2);
      rd_chk(2'd0, 32'h0, "midrst_data");
      rd_chk(2'd2, 32'h0, "midrst_edge");
      rd_chk(2'd1, 32'h0, "midrst_mask");
      idle(8);
      rd_chk(2'd0, 32'h0, "midrst_data_late");
      check("midrst_irq_after", {31'b0, irq}, 32'h0);

      // Register map corners
      wr(2'd1, 32'hFFFF_FFFF);
      rd_chk(2'd1, 32'h3, "mask_upper_zero");
      idle(3);
      check("readdata_hold", readdata, 32'h3);
      wr(2'd3, 32'hFFFF_FFFF);
      rd_chk(2'd3, 32'h0, "addr3_reads_zero");
      rd_chk(2'd1, 32'h3, "addr3_write_ignored");
      bus(1'b1, 1'b1, 2'd1, 32'h0);
      check("rw_same_addr_prewrite", readdata, 32'h3);
      rd_chk(2'd1, 32'h0, "rw_same_addr_written");
      chipselect = 1'b0;
      write      = 1'b1;
      address    = 2'd1;
      writedata  = 32'h1;
      idle(1);
      write      = 1'b0;
      rd_chk(2'd1, 32'h0, "write_needs_cs");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uab_key_pio.md
UAB_KEY_PIO -- requirements
Module: uab_key_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the number of key inputs.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the stable-time qualifier in clk cycles (20 ms at 50 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit, the reset: asynchronous assertion, active-low.
REQ-005 The block SHALL have port key_in, input, WIDTH bits, raw asynchronous keys, active-low (0 = pressed).
REQ-006 The block SHALL have port chipselect, input, 1 bit, Avalon-MM slave select.
REQ-007 The block SHALL have port address, input, 2 bits, word address.
REQ-008 The block SHALL have port read, input, 1 bit, read strobe.
REQ-009 The block SHALL have port write, input, 1 bit, write strobe.
REQ-010 The block SHALL have port writedata, input, 32 bits, write data.
REQ-011 The block SHALL have port readdata, output, 32 bits, registered read data.
REQ-012 The block SHALL have port irq, output, 1 bit, level interrupt request, active-high.

Function
REQ-013 Each key_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each bit SHALL keep a stable state, 1 = pressed, plus a counter.
- Counter clears while the synchronized (inverted) value equals stable.
- Counter increments while it differs.
- On the cycle the counter reaches DEBOUNCE_CYCLES-1, stable toggles and the counter clears.
REQ-015 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change stable.
REQ-016 The counter width SHALL be $clog2(DEBOUNCE_CYCLES) and the counter SHALL never wrap.
REQ-017 A 0->1 transition of stable[i] SHALL set edge[i] in the same cycle stable updates.
REQ-018 The register map SHALL be:
- 0 DATA: read-only, stable in bits [WIDTH-1:0].
- 1 MASK: read/write, bits [WIDTH-1:0].
- 2 EDGE: read returns edge; writing 1 clears the bit.
- 3: reads 0, writes ignored.
- Unused upper bits read 0.
REQ-019 Writes SHALL take effect only when chipselect and write are both high.
REQ-020 Reads SHALL have fixed latency 1: readdata is valid the cycle after chipselect&read and holds until the next read.
REQ-021 If a new edge and a write-1-clear hit the same bit in the same cycle, the set SHALL win.
REQ-022 irq SHALL be registered and equal |(edge & MASK), one cycle after either register changes.
REQ-023 Simultaneous read and write to the same address SHALL return the pre-write value.

Reset
REQ-024 While reset_n is low, all state SHALL be held at:
- synchronizer flops 1 (released);
- stable 0, counters 0;
- MASK 0, EDGE 0;
- readdata 0, irq 0.
REQ-025 Release of reset_n SHALL be usable directly from the synchronized system reset; no edge SHALL be captured due to the reset itself.
REQ-026 Reset asserted mid-debounce SHALL abort the count with no stable change.

Structure
REQ-027 Register offsets and the default DEBOUNCE_CYCLES SHALL live in the shared uab_rv_pkg constants file.
REQ-028 Per-bit synchronizer, counter and stable state SHALL be a sub-module uab_debounce, instantiated WIDTH times by generate.

Verification
REQ-029 The bench SHALL cover the following directed scenarios, all with DEBOUNCE_CYCLES=4:
- key_in[0] low for 3 cycles, then high -> DATA reads 0, EDGE reads 0.
- key_in[0] held low for 10 cycles -> stable[0] = 1 exactly 2+4 cycles after the input change; EDGE reads 0x1.
- MASK write 0x1, then press key 0 -> irq = 1; EDGE write 0x1 -> irq = 0 one cycle later.
- Press on key 1 coincident with an EDGE write 0x2 -> EDGE[1] stays 1.
- Reset_n pulsed low mid-count (count = 2) -> after release DATA = 0, EDGE = 0, irq = 0.
- Read address 3 after a write 0xFFFFFFFF -> readdata = 0 on the following cycle.
